// File: rtl/mc_control_unit.sv
// Multi-cycle sequencing controller for an RV32I-subset CPU: fetch/decode/execute/
// memory/write-back state machine, datapath strobes, cycle and retire counters.
module mc_control_unit #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             zero,
   input  logic             sign,
   output logic [2:0]       state,
   output logic             IRWr,
   output logic             PCWre,
   output logic [1:0]       PCSrc,
   output logic             RegWre,
   output logic             ALUSrcB,
   output logic [3:0]       ALUOp,
   output logic [2:0]       ExtSel,
   output logic             MemRd,
   output logic             MemWr,
   output logic [1:0]       WrSrc,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;

   state_t           r_state;
   state_t           w_state_next;
   state_t           w_dec_state;
   logic             r_halted;
   logic             w_halted_next;
   logic             w_dec_halted;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instr_cnt;
   logic [3:0]       w_alu_op;
   logic             w_taken;
   logic             w_is_r, w_is_i, w_is_br, w_is_lw, w_is_sw, w_is_jal;

   assign w_is_r   = (op == OP_R);
   assign w_is_i   = (op == OP_I);
   assign w_is_br  = (op == OP_BR);
   assign w_is_lw  = (op == OP_LW);
   assign w_is_sw  = (op == OP_SW);
   assign w_is_jal = (op == OP_JAL);

   // funct7b5 selects sub only for R-type; shifts use it for both R and I forms.
   always_comb begin
      w_alu_op = ALU_ADD;
      case (funct3)
         3'b000:  w_alu_op = (w_is_r && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  w_alu_op = ALU_SLL;
         3'b010:  w_alu_op = ALU_SLT;
         3'b011:  w_alu_op = ALU_SLTU;
         3'b100:  w_alu_op = ALU_XOR;
         3'b101:  w_alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  w_alu_op = ALU_OR;
         default: w_alu_op = ALU_AND;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (funct3)
         3'b000:  w_taken = zero;
         3'b001:  w_taken = !zero;
         3'b100:  w_taken = sign;
         3'b101:  w_taken = !sign;
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_state_next  = r_state;
      w_halted_next = r_halted;
      if (!r_halted) begin
         case (r_state)
            S_IF:     w_state_next = S_ID;
            S_ID: begin
               if (w_is_r || w_is_i)        w_state_next = S_EXE_AL;
               else if (w_is_br)            w_state_next = S_EXE_BR;
               else if (w_is_lw || w_is_sw) w_state_next = S_EXE_LS;
               else if (w_is_jal)           w_state_next = S_IF;
               else begin
                  w_state_next  = S_IF;
                  w_halted_next = 1'b1;
               end
            end
            S_EXE_AL: w_state_next = S_WB_AL;
            S_EXE_LS: w_state_next = S_MEM;
            S_MEM:    w_state_next = w_is_lw ? S_WB_LD : S_IF;
            default:  w_state_next = S_IF;
         endcase
      end
   end

   // While RST is high the outputs decode as IF so an interrupted store never strobes.
   assign w_dec_state  = RST ? S_IF : r_state;
   assign w_dec_halted = RST ? 1'b0 : r_halted;

   always_comb begin
      IRWr    = 1'b0;
      PCWre   = 1'b0;
      PCSrc   = 2'b00;
      RegWre  = 1'b0;
      ALUSrcB = 1'b0;
      ALUOp   = ALU_ADD;
      ExtSel  = 3'b000;
      MemRd   = 1'b0;
      MemWr   = 1'b0;
      WrSrc   = 2'b00;
      if (!w_dec_halted) begin
         case (w_dec_state)
            S_IF: IRWr = 1'b1;
            S_ID: begin
               if (w_is_jal) begin
                  RegWre = 1'b1;
                  WrSrc  = 2'b10;
                  ExtSel = 3'b011;
                  PCSrc  = 2'b01;
                  PCWre  = 1'b1;
               end
            end
            S_EXE_AL, S_WB_AL: begin
               ALUSrcB = w_is_i;
               ALUOp   = w_alu_op;
               if (w_dec_state == S_WB_AL) begin
                  RegWre = 1'b1;
                  PCWre  = 1'b1;
               end
            end
            S_EXE_BR: begin
               ALUOp  = ALU_SUB;
               ExtSel = 3'b010;
               PCWre  = 1'b1;
               PCSrc  = w_taken ? 2'b01 : 2'b00;
            end
            S_EXE_LS, S_MEM: begin
               ALUSrcB = 1'b1;
               ExtSel  = w_is_sw ? 3'b001 : 3'b000;
               if (w_dec_state == S_MEM) begin
                  MemRd = w_is_lw;
                  MemWr = w_is_sw;
                  PCWre = w_is_sw;
               end
            end
            default: begin
               MemRd  = 1'b1;
               RegWre = 1'b1;
               WrSrc  = 2'b01;
               PCWre  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_IF;
         r_halted    <= 1'b0;
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         r_state  <= w_state_next;
         r_halted <= w_halted_next;
         if (!r_halted) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         if (PCWre)     r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
   end

   assign state     = w_dec_state;
   assign halted    = w_dec_halted;
   assign cycle_cnt = r_cycle_cnt;
   assign instr_cnt = r_instr_cnt;

endmodule
